// File: rtl/muldiv_hilo_unit.sv
// Multi-cycle multiply/divide unit that owns the HI/LO register pair.
// Multiply: fixed-latency countdown, then the full 2*XLEN product is written.
// Divide: radix-2 restoring divider, one quotient bit per cycle, sign fixup at the end.
module muldiv_hilo_unit #(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int CNT_W = $clog2(XLEN + MUL_STAGES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [CNT_W-1:0]    cnt_reg;
    logic                busy_reg;
    logic                done_reg;
    logic                ready_reg;
    logic [XLEN-1:0]     hi_reg;
    logic [XLEN-1:0]     lo_reg;

    // opa: multiplicand, or dividend bits shifting out / quotient bits shifting in
    // opb: multiplier, or divisor magnitude
    logic [XLEN-1:0]     opa_reg;
    logic [XLEN-1:0]     opb_reg;
    logic [XLEN-1:0]     rem_reg;
    logic [XLEN-1:0]     dividend_reg;
    logic                mul_signed_reg;
    logic                q_neg_reg;
    logic                r_neg_reg;
    logic                div_zero_reg;

    logic                accept;
    logic                is_div_signed;
    logic [XLEN-1:0]     src1_mag;
    logic [XLEN-1:0]     src2_mag;
    logic [2*XLEN-1:0]   mul_a_ext;
    logic [2*XLEN-1:0]   mul_b_ext;
    logic [2*XLEN-1:0]   product;
    logic [XLEN:0]       div_shifted;
    logic [XLEN:0]       div_trial;
    logic                div_fits;
    logic [XLEN-1:0]     rem_next;
    logic [XLEN-1:0]     quo_next;
    logic [XLEN-1:0]     quo_final;
    logic [XLEN-1:0]     rem_final;

    assign accept        = req_valid & (state_reg == ST_IDLE) & ~flush;
    assign is_div_signed = (req_op == 3'd2);

    assign req_ready = ready_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign hi        = hi_reg;
    assign lo        = lo_reg;

    // Operand magnitudes at accept, full product, and one restoring-divide step
    always_comb begin
        src1_mag    = (is_div_signed && src1[XLEN-1]) ? -src1 : src1;
        src2_mag    = (is_div_signed && src2[XLEN-1]) ? -src2 : src2;
        // Sign-extending both operands to 2*XLEN makes the low half of a plain
        // multiply equal to the signed product; zero-extension gives unsigned.
        mul_a_ext   = {{XLEN{mul_signed_reg & opa_reg[XLEN-1]}}, opa_reg};
        mul_b_ext   = {{XLEN{mul_signed_reg & opb_reg[XLEN-1]}}, opb_reg};
        product     = mul_a_ext * mul_b_ext;
        div_shifted = {rem_reg, opa_reg[XLEN-1]};
        div_trial   = div_shifted - {1'b0, opb_reg};
        div_fits    = ~div_trial[XLEN];
        rem_next    = div_fits ? div_trial[XLEN-1:0] : div_shifted[XLEN-1:0];
        quo_next    = {opa_reg[XLEN-2:0], div_fits};
        quo_final   = q_neg_reg ? -quo_next : quo_next;
        rem_final   = r_neg_reg ? -rem_next : rem_next;
    end

    // Next-state decode; status outputs are registered from it
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept && (req_op == 3'd0 || req_op == 3'd1)) begin
                    state_next = ST_MUL;
                end else if (accept && (req_op == 3'd2 || req_op == 3'd3)) begin
                    state_next = ST_DIV;
                end
            end
            ST_MUL, ST_DIV: begin
                if (flush) begin
                    state_next = ST_IDLE;
                end else if (cnt_reg == '0) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM, operand/divider datapath registers and HI/LO updates
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= ST_IDLE;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            ready_reg      <= 1'b1;
            cnt_reg        <= '0;
            hi_reg         <= '0;
            lo_reg         <= '0;
            opa_reg        <= '0;
            opb_reg        <= '0;
            rem_reg        <= '0;
            dividend_reg   <= '0;
            mul_signed_reg <= 1'b0;
            q_neg_reg      <= 1'b0;
            r_neg_reg      <= 1'b0;
            div_zero_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next != ST_IDLE);
            done_reg  <= (state_next == ST_DONE);
            ready_reg <= (state_next == ST_IDLE);
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        case (req_op)
                            3'd0, 3'd1: begin
                                opa_reg        <= src1;
                                opb_reg        <= src2;
                                mul_signed_reg <= (req_op == 3'd0);
                                cnt_reg        <= CNT_W'(MUL_STAGES - 1);
                            end
                            3'd2, 3'd3: begin
                                opa_reg        <= src1_mag;
                                opb_reg        <= src2_mag;
                                rem_reg        <= '0;
                                dividend_reg   <= src1;
                                q_neg_reg      <= is_div_signed & (src1[XLEN-1] ^ src2[XLEN-1]);
                                r_neg_reg      <= is_div_signed & src1[XLEN-1];
                                div_zero_reg   <= (src2 == '0);
                                cnt_reg        <= CNT_W'(XLEN - 1);
                            end
                            3'd4: hi_reg <= src1;
                            3'd5: lo_reg <= src1;
                            default: ;
                        endcase
                    end
                end
                ST_MUL: begin
                    if (!flush) begin
                        if (cnt_reg == '0) begin
                            {hi_reg, lo_reg} <= product;
                        end else begin
                            cnt_reg <= cnt_reg - CNT_W'(1);
                        end
                    end
                end
                ST_DIV: begin
                    if (!flush) begin
                        opa_reg <= quo_next;
                        rem_reg <= rem_next;
                        if (cnt_reg == '0) begin
                            // Zero divisor returns all-ones quotient and the raw dividend
                            if (div_zero_reg) begin
                                lo_reg <= '1;
                                hi_reg <= dividend_reg;
                            end else begin
                                lo_reg <= quo_final;
                                hi_reg <= rem_final;
                            end
                        end else begin
                            cnt_reg <= cnt_reg - CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// Self-checking bench for muldiv_hilo_unit: vector table, random ops against a
// behavioural model, and hand-written flush/reset/MTHI/MTLO sequences.
module tb_muldiv_hilo_unit;

    localparam int XLEN       = 32;
    localparam int MUL_STAGES = 2;
    localparam int NVEC       = 12;
    localparam int NRAND      = 6;

    logic            clk = 1'b0;
    logic            resetn;
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_op;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    vec_t vecs[NVEC];
    exp_t sb_q[$];
    int   checks   = 0;
    int   passed   = 0;
    int   done_cnt = 0;

    muldiv_hilo_unit #(.XLEN(XLEN), .MUL_STAGES(MUL_STAGES)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .src1      (src1),
        .src2      (src2),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    // Count every cycle in which done is high
    always @(posedge clk) begin
        if (done === 1'b1) done_cnt++;
    end

    // Hard stop in case something wedges
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
        logic [63:0] p;
        int          sa;
        int          sb;
        h = '0;
        l = '0;
        sa = a;
        sb = b;
        case (op)
            3'd0: begin
                p = longint'(sa) * longint'(sb);
                h = p[63:32];
                l = p[31:0];
            end
            3'd1: begin
                p = {32'd0, a} * {32'd0, b};
                h = p[63:32];
                l = p[31:0];
            end
            3'd2: begin
                if (b == 32'd0) begin
                    l = 32'hFFFFFFFF; h = a;
                end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                    l = 32'h80000000; h = 32'd0;
                end else begin
                    l = sa / sb; h = sa % sb;
                end
            end
            default: begin
                if (b == 32'd0) begin
                    l = 32'hFFFFFFFF; h = a;
                end else begin
                    l = a / b; h = a % b;
                end
            end
        endcase
    endfunction

    // Issue one MUL/DIV op, push its expectation, wait for done, pop and compare
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] hi_e, input logic [31:0] lo_e);
        exp_t e;
        int   cyc;
        e.hi  = hi_e;
        e.lo  = lo_e;
        e.lat = (op < 3'd2) ? MUL_STAGES + 1 : XLEN + 1;
        sb_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b1; req_op = op; src1 = a; src2 = b;
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        e = sb_q.pop_front();
        $display("op=%0d a=%h b=%h -> hi=%h lo=%h lat=%0d", op, a, b, hi, lo, cyc);
        check({tag, "_latency"}, cyc, e.lat);
        check({tag, "_hi"}, hi, e.hi);
        check({tag, "_lo"}, lo, e.lo);
        check({tag, "_ready_in_done"}, {31'd0, req_ready}, 32'd0);
        @(negedge clk);
    endtask

    task automatic move_to(input logic [2:0] op, input logic [31:0] val);
        @(negedge clk);
        req_valid = 1'b1; req_op = op; src1 = val;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    initial begin
        int          snap;
        logic [31:0] rh;
        logic [31:0] rl;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        vecs[0]  = '{3'd0, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{3'd3, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF};
        vecs[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5]  = '{3'd3, 32'd100,      32'd7,        32'd2,        32'd14};
        vecs[6]  = '{3'd2, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        vecs[7]  = '{3'd0, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9};
        vecs[8]  = '{3'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        vecs[9]  = '{3'd2, 32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF};
        vecs[10] = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[11] = '{3'd3, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF};

        resetn = 1'b0; req_valid = 1'b0; req_op = 3'd0; src1 = '0; src2 = '0; flush = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        check("reset_ready", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < NVEC; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo);
        end

        for (int i = 0; i < NRAND; i++) begin
            rop = 3'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            if (i == 0) rb = 32'd0;
            model(rop, ra, rb, rh, rl);
            run_op($sformatf("rand%0d", i), rop, ra, rb, rh, rl);
        end

        // MTHI then MTLO back to back: no done pulse, unit stays idle
        snap = done_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd4; src1 = 32'h1234;
        @(negedge clk);
        req_op = 3'd5; src1 = 32'h5678;
        @(negedge clk);
        req_valid = 1'b0;
        check("mt_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        $display("mthi/mtlo -> hi=%h lo=%h", hi, lo);
        check("mthi_hi", hi, 32'h1234);
        check("mtlo_lo", lo, 32'h5678);
        check("mt_no_done", done_cnt, snap);

        // Ops 6/7 are accepted and dropped
        move_to(3'd6, 32'hDEADBEEF);
        move_to(3'd7, 32'hDEADBEEF);
        $display("op6/op7 -> hi=%h lo=%h busy=%0d", hi, lo, busy);
        check("op67_busy", {31'd0, busy}, 32'd0);
        check("op67_hi", hi, 32'h1234);
        check("op67_lo", lo, 32'h5678);

        // Flush in IDLE blocks acceptance
        flush = 1'b1;
        move_to(3'd4, 32'hAAAA);
        flush = 1'b0;
        $display("flush idle -> hi=%h", hi);
        check("flush_idle_hi", hi, 32'h1234);

        // DIVU flushed mid-way
        snap = done_cnt;
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd3; src1 = 32'd100; src2 = 32'd7;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (8) @(negedge clk);
        check("div_mid_busy", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        $display("divu flush -> busy=%0d hi=%h lo=%h", busy, hi, lo);
        check("div_flush_busy", {31'd0, busy}, 32'd0);
        check("div_flush_ready", {31'd0, req_ready}, 32'd1);
        repeat (40) @(negedge clk);
        check("div_flush_hi", hi, 32'h1234);
        check("div_flush_lo", lo, 32'h5678);
        check("div_flush_no_done", done_cnt, snap);

        // MULT flushed on its final (cnt==0) edge
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd0; src1 = 32'd3; src2 = 32'd5;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (MUL_STAGES - 1) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        repeat (3) @(negedge clk);
        $display("mult last-edge flush -> hi=%h lo=%h", hi, lo);
        check("mul_lastflush_busy", {31'd0, busy}, 32'd0);
        check("mul_lastflush_hi", hi, 32'h1234);
        check("mul_lastflush_lo", lo, 32'h5678);
        check("mul_lastflush_no_done", done_cnt, snap);

        // DIV flushed on its final (cnt==0) edge
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd2; src1 = 32'd50; src2 = 32'd3;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (XLEN - 1) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        repeat (3) @(negedge clk);
        $display("div last-edge flush -> hi=%h lo=%h", hi, lo);
        check("div_lastflush_lo", lo, 32'h5678);
        check("div_lastflush_no_done", done_cnt, snap);

        // Flush during DONE is ignored: result stays committed, one done pulse
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd1; src1 = 32'd6; src2 = 32'd7;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (MUL_STAGES) @(negedge clk);
        check("done_state_busy", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        $display("flush in done -> hi=%h lo=%h", hi, lo);
        check("done_flush_lo", lo, 32'd42);
        check("done_flush_hi", hi, 32'd0);
        check("done_flush_pulses", done_cnt, snap + 1);
        check("done_flush_idle", {31'd0, busy}, 32'd0);

        // Reset in the middle of a DIVU
        move_to(3'd4, 32'hBEEF);
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd3; src1 = 32'hFFFF; src2 = 32'd3;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_mid_busy_before", {31'd0, busy}, 32'd1);
        resetn = 1'b0;
        #1;
        $display("reset mid-div -> hi=%h lo=%h busy=%0d", hi, lo, busy);
        check("rst_mid_hi", hi, 32'd0);
        check("rst_mid_lo", lo, 32'd0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("rst_mid_ready", {31'd0, req_ready}, 32'd1);
        run_op("post_reset", 3'd1, 32'd2, 32'd3, 32'd0, 32'd6);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
